// File: rtl/memory_reader.sv
// Arbitrated burst read client: acquires the shared memory bus, reads `count`
// consecutive words from `addr` and hands each one to the controller.
module memory_reader #(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int CW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic [AW-1:0] addr,
  input  logic [CW-1:0] count,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          done,
  output logic          error,
  output logic          arb_request,
  input  logic          arb_grant,
  output logic [AW-1:0] mem_rd_addr,
  output logic          mem_rd_enable,
  input  logic          mem_busy,
  input  logic [DW-1:0] mem_rd_data
);

  localparam int TW = ($clog2(TIMEOUT + 1) < 4) ? 4 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_GRANT = 3'd1,
    PRE_READ   = 3'd2,
    READ       = 3'd3,
    DELIVER    = 3'd4,
    POST       = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cur_addr_q, cur_addr_d;
  logic [CW-1:0] remaining_q, remaining_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_flag_q, err_flag_d;
  logic [DW-1:0] out_data_q, out_data_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      tmo_q       <= '0;
      err_flag_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      tmo_q       <= tmo_d;
      err_flag_q  <= err_flag_d;
      out_data_q  <= out_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    tmo_d       = tmo_q;
    err_flag_d  = err_flag_q;
    out_data_d  = out_data_q;
    case (state_q)
      // IDLE and POST accept a new request identically; POST returns to IDLE
      // when no request is pending.
      IDLE, POST: begin
        if (req) begin
          err_flag_d = 1'b0;
          if (count != '0) begin
            cur_addr_d  = addr;
            remaining_d = count;
            state_d     = WAIT_GRANT;
          end else begin
            state_d = POST;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_GRANT: begin
        if (arb_grant) begin
          tmo_d   = '0;
          state_d = PRE_READ;
        end
      end
      PRE_READ: begin
        if (mem_busy) begin
          state_d = READ;
        end else if (tmo_q == TW'(TIMEOUT)) begin
          err_flag_d = 1'b1;
          state_d    = POST;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      READ: begin
        if (!mem_busy) begin
          out_data_d = mem_rd_data;
          state_d    = DELIVER;
        end
      end
      // Valid/ready: out_valid is high for the whole DELIVER state and
      // out_data is frozen; a word transfers on a clock edge where both
      // out_valid and out_ready are 1. out_valid never depends on out_ready.
      DELIVER: begin
        if (out_ready) begin
          remaining_d = remaining_q - 1'b1;
          cur_addr_d  = cur_addr_q + 1'b1;
          if (remaining_q == CW'(1)) begin
            state_d = POST;
          end else begin
            tmo_d   = '0;
            state_d = PRE_READ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_data    = out_data_q;
  assign out_valid   = (state_q == DELIVER);
  assign done        = (state_q == POST);
  assign error       = (state_q == POST) && err_flag_q;
  assign arb_request = (state_q == WAIT_GRANT) || (state_q == PRE_READ) ||
                       (state_q == READ) || (state_q == DELIVER);

  // Shared bus: release the address outside an access and the strobe whenever
  // another client owns the bus.
  assign mem_rd_addr   = ((state_q == PRE_READ) || (state_q == READ)) ? cur_addr_q : {AW{1'bz}};
  assign mem_rd_enable = arb_grant ? (state_q == PRE_READ) : 1'bz;

endmodule

// File: tb/tb_memory_reader.sv
// Self-checking bench for memory_reader: arbiter and memory models, a word
// scoreboard, and directed bursts covering wrap, backpressure, timeout and reset.
module tb_memory_reader;

  localparam int AW      = 16;
  localparam int DW      = 16;
  localparam int CW      = 8;
  localparam int TIMEOUT = 15;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst   = 1'b1;
  logic          req   = 1'b0;
  logic [AW-1:0] addr  = '0;
  logic [CW-1:0] count = '0;

  logic          out_ready   = 1'b1;
  logic          arb_grant   = 1'b0;
  logic          mem_busy    = 1'b0;
  logic [DW-1:0] mem_rd_data = '0;

  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          done;
  logic          error;
  logic          arb_request;
  tri0 [AW-1:0]  mem_rd_addr;
  tri1           mem_rd_enable;

  memory_reader #(.AW(AW), .DW(DW), .CW(CW), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .addr         (addr),
    .count        (count),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .done         (done),
    .error        (error),
    .arb_request  (arb_request),
    .arb_grant    (arb_grant),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_enable(mem_rd_enable),
    .mem_busy     (mem_busy),
    .mem_rd_data  (mem_rd_data)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- scoreboard and models ----------------
  logic [DW-1:0] exp_q[$];

  // knobs set by the test sequence
  int            busy_len    = 2;
  logic          mem_dead    = 1'b0;
  logic [DW-1:0] data_xor    = '0;
  int            ready_mode  = 0;
  int            grant_delay = 0;
  logic          hz_chk      = 1'b0;

  // observations written only by the monitor
  int            busy_left    = 0;
  logic          en_prev      = 1'b0;
  logic [AW-1:0] mem_addr_l   = '0;
  int            en_pulses    = 0;
  int            en_rise_cyc  = 0;
  logic [AW-1:0] addr_log[$];
  int            req_cycles   = 0;
  int            words_rx     = 0;
  int            valid_cycles = 0;
  int            arb_cycles   = 0;
  logic          pend         = 1'b0;
  logic [DW-1:0] pend_data    = '0;

  always @(negedge clk) begin : mon
    logic en;
    en = arb_grant && (mem_rd_enable === 1'b1);
    if (hz_chk && arb_request && !arb_grant) begin
      check("hz_addr", 32'(mem_rd_addr), 32'h0000);
      check("hz_enable", 32'(mem_rd_enable), 32'h1);
    end
    // memory: busy for busy_len cycles after each rising read strobe
    if (busy_left > 0) busy_left--;
    if (en && !en_prev) begin
      en_pulses++;
      en_rise_cyc = cyc;
      addr_log.push_back(mem_rd_addr);
      mem_addr_l = mem_rd_addr;
      if (!mem_dead) busy_left = busy_len;
    end
    en_prev     = en;
    mem_busy    = (busy_left > 0);
    mem_rd_data = mem_addr_l ^ data_xor;
    // controller side
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = 1'b0;
    endcase
    if (out_valid) begin
      valid_cycles++;
      if (pend) check("data_stable", 32'(out_data), 32'(pend_data));
      if (out_ready) begin
        words_rx++;
        pend = 1'b0;
        if (exp_q.size() == 0) check("unexpected_word", 32'(exp_q.size()), 32'd1);
        else check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
      end else begin
        pend      = 1'b1;
        pend_data = out_data;
      end
    end else begin
      pend = 1'b0;
    end
    if (arb_request) arb_cycles++;
    // arbiter: grant after grant_delay cycles of request, drop with request
    if (arb_request) begin
      req_cycles++;
      arb_grant = (req_cycles > grant_delay);
    end else begin
      req_cycles = 0;
      arb_grant  = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  int req_cyc = 0;

  task automatic start_burst(input logic [AW-1:0] a, input logic [CW-1:0] c);
    @(negedge clk);
    req     = 1'b1;
    addr    = a;
    count   = c;
    req_cyc = cyc;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_done(input int budget, output logic seen, output int dcyc, output logic derr);
    seen = 1'b0;
    dcyc = 0;
    derr = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        seen = 1'b1;
        dcyc = cyc;
        derr = error;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- test sequence ----------------
  initial begin : seq
    logic seen, derr;
    int   dcyc, base_en, base_words, base_valid, base_arb, base_log;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_done", 32'(done), 0);
    check("rst_error", 32'(error), 0);
    check("rst_arb_request", 32'(arb_request), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_addr_hz", 32'(mem_rd_addr), 0);
    check("rst_enable_hz", 32'(mem_rd_enable), 1);

    // single word
    data_xor   = 16'hBEFF;
    busy_len   = 2;
    ready_mode = 0;
    base_words = words_rx;
    exp_q.push_back(16'hBEEF);
    start_burst(16'h0010, 8'd1);
    wait_done(100, seen, dcyc, derr);
    check("t1_done", 32'(seen), 1);
    check("t1_error", 32'(derr), 0);
    check("t1_arb_post", 32'(arb_request), 0);
    check("t1_words", 32'(words_rx - base_words), 1);
    @(negedge clk);
    check("t1_done_pulse", 32'(done), 0);

    // burst with backpressure
    data_xor   = 16'hA5A5;
    ready_mode = 1;
    base_en    = en_pulses;
    base_words = words_rx;
    exp_q.push_back(16'hA4A5);
    exp_q.push_back(16'hA4A4);
    exp_q.push_back(16'hA4A7);
    exp_q.push_back(16'hA4A6);
    start_burst(16'h0100, 8'd4);
    wait_done(300, seen, dcyc, derr);
    ready_mode = 0;
    check("t2_done", 32'(seen), 1);
    check("t2_error", 32'(derr), 0);
    check("t2_words", 32'(words_rx - base_words), 4);
    check("t2_enable_pulses", 32'(en_pulses - base_en), 4);

    // wrap and late grant
    data_xor    = 16'h0000;
    grant_delay = 5;
    hz_chk      = 1'b1;
    base_log    = addr_log.size();
    exp_q.push_back(16'hFFFF);
    exp_q.push_back(16'h0000);
    start_burst(16'hFFFF, 8'd2);
    wait_done(200, seen, dcyc, derr);
    hz_chk      = 1'b0;
    grant_delay = 0;
    check("t3_done", 32'(seen), 1);
    check("t3_addr_count", 32'(addr_log.size() - base_log), 2);
    if (addr_log.size() >= base_log + 2) begin
      check("t3_addr0", 32'(addr_log[base_log]), 32'hFFFF);
      check("t3_addr1", 32'(addr_log[base_log+1]), 32'h0000);
    end

    // timeout
    mem_dead   = 1'b1;
    base_valid = valid_cycles;
    base_en    = en_pulses;
    start_burst(16'h0200, 8'd3);
    wait_done(200, seen, dcyc, derr);
    mem_dead = 1'b0;
    check("t4_done", 32'(seen), 1);
    check("t4_error", 32'(derr), 1);
    check("t4_strobe_seen", 32'(en_pulses - base_en), 1);
    check("t4_latency", 32'(dcyc - en_rise_cyc), TIMEOUT + 1);
    check("t4_no_valid", 32'(valid_cycles - base_valid), 0);
    @(negedge clk);
    check("t4_done_pulse", 32'(done), 0);

    // count = 0
    base_arb = arb_cycles;
    start_burst(16'h1234, 8'd0);
    wait_done(10, seen, dcyc, derr);
    check("t5_done", 32'(seen), 1);
    check("t5_latency", 32'(dcyc - req_cyc), 1);
    check("t5_error", 32'(derr), 0);
    repeat (2) @(negedge clk);
    check("t5_no_arb", 32'(arb_cycles - base_arb), 0);

    // back-to-back with req held high
    data_xor   = 16'h1111;
    base_words = words_rx;
    exp_q.push_back(16'h1211);
    exp_q.push_back(16'h1210);
    exp_q.push_back(16'h1511);
    @(negedge clk);
    req   = 1'b1;
    addr  = 16'h0300;
    count = 8'd2;
    wait_done(200, seen, dcyc, derr);
    check("t6_done1", 32'(seen), 1);
    addr  = 16'h0400;
    count = 8'd1;
    @(negedge clk);
    check("t6_direct_wait_grant", 32'(arb_request), 1);
    check("t6_done1_pulse", 32'(done), 0);
    req = 1'b0;
    wait_done(200, seen, dcyc, derr);
    check("t6_done2", 32'(seen), 1);
    check("t6_words", 32'(words_rx - base_words), 3);

    // reset during DELIVER
    data_xor   = 16'h5A5A;
    ready_mode = 2;
    start_burst(16'h0500, 8'd2);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("t7_reached_deliver", 32'(seen), 1);
    rst = 1'b1;
    @(negedge clk);
    check("t7_out_valid", 32'(out_valid), 0);
    check("t7_done", 32'(done), 0);
    check("t7_error", 32'(error), 0);
    check("t7_arb_request", 32'(arb_request), 0);
    check("t7_out_data", 32'(out_data), 0);
    rst        = 1'b0;
    ready_mode = 0;
    @(negedge clk);
    check("t7_enable_hz", 32'(mem_rd_enable), 1);
    check("t7_addr_hz", 32'(mem_rd_addr), 0);

    // recovery burst after reset
    data_xor = 16'h0F0F;
    exp_q.push_back(16'h0A0F);
    start_burst(16'h0500, 8'd1);
    wait_done(100, seen, dcyc, derr);
    check("t8_done", 32'(seen), 1);
    check("t8_error", 32'(derr), 0);

    repeat (3) @(negedge clk);
    check("exp_q_empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
